// File: rtl/eth_frame_packer.sv
// eth_frame_packer: captures 16-bit FIFO words into ping-pong banks per channel and streams headered byte frames (ports: clk, rst, eth_en/addr/din capture in, tx_data/tx_valid/tx_last/tx_ready byte stream, busy, drop_count)
module eth_frame_packer #(
  parameter int MAX_WORDS = 1024,
  parameter logic [7:0] HDR_MAGIC = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eth_en,
  input  logic [2:0]  addr,
  input  logic [15:0] din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] drop_count
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int PW = $clog2(MAX_WORDS);
  localparam int BW = $clog2(2 * MAX_WORDS + 9);
  typedef enum logic [1:0] {FREE, FILLING, READY, SENDING} bank_t;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} tx_t;
  logic [15:0] mem [2][MAX_WORDS];
  logic v_q, v_d;
  logic [2:0] chan_q, chan_d;
  bank_t bst_q [2], bst_d [2];
  logic [2:0] bch_q [2], bch_d [2];
  logic [CW-1:0] bcnt_q [2], bcnt_d [2];
  logic bdrop_q [2], bdrop_d [2];
  logic fill_act_q, fill_act_d, fill_b_q, fill_b_d, older_q, older_d, pend_q, pend_d;
  logic [15:0] drop_cnt_q, drop_cnt_d, seq_q, seq_d;
  tx_t txs_q, txs_d;
  logic txb_q, txb_d;
  logic [BW-1:0] ptr_q, ptr_d, p;
  logic [7:0] td_q, td_d, hdr;
  logic tv_q, tv_d, tl_q, tl_d;
  logic we, wb, nb, need_new, pick;
  logic [PW-1:0] waddr;
  logic [15:0] word, cnt16;
  assign v_d = eth_en;
  assign chan_d = addr;
  assign tx_data = td_q;
  assign tx_valid = tv_q;
  assign tx_last = tl_q;
  assign drop_count = drop_cnt_q;
  assign busy = bst_q[0] != FREE || bst_q[1] != FREE || txs_q != IDLE;
  assign p = ptr_q - BW'(8);
  assign word = mem[txb_q][p[PW:1]];
  assign cnt16 = 16'(bcnt_q[txb_q]);
  assign hdr = ptr_q[2:0] == 3'd1 ? {5'b0, bch_q[txb_q]} :
               ptr_q[2:0] == 3'd2 ? seq_q[15:8] :
               ptr_q[2:0] == 3'd3 ? seq_q[7:0] :
               ptr_q[2:0] == 3'd4 ? cnt16[15:8] :
               ptr_q[2:0] == 3'd5 ? cnt16[7:0] :
               ptr_q[2:0] == 3'd6 ? {7'b0, bdrop_q[txb_q]} :
               ptr_q[2:0] == 3'd7 ? 8'h00 : HDR_MAGIC;
  assign pick = bst_q[0] == READY && bst_q[1] == READY ? older_q : bst_q[1] == READY;
  always_comb begin
    bst_d = bst_q;
    bch_d = bch_q;
    bcnt_d = bcnt_q;
    bdrop_d = bdrop_q;
    fill_act_d = fill_act_q;
    fill_b_d = fill_b_q;
    older_d = older_q;
    pend_d = pend_q;
    drop_cnt_d = drop_cnt_q;
    we = 1'b0;
    wb = fill_b_q;
    waddr = bcnt_q[fill_b_q][PW-1:0];
    need_new = v_q && !fill_act_q;
    nb = fill_act_q ? ~fill_b_q : bst_q[0] != FREE;
    // A bank that closes while the other is already READY is the younger one.
    if (fill_act_q && (!v_q || chan_q != bch_q[fill_b_q] || bcnt_q[fill_b_q] == CW'(MAX_WORDS - 1))) begin
      bst_d[fill_b_q] = READY;
      fill_act_d = 1'b0;
      older_d = bst_q[~fill_b_q] == READY ? ~fill_b_q : fill_b_q;
    end
    if (fill_act_q && v_q && chan_q == bch_q[fill_b_q]) begin
      we = 1'b1;
      bcnt_d[fill_b_q] = bcnt_q[fill_b_q] + CW'(1);
    end else if (fill_act_q && v_q)
      need_new = 1'b1;
    if (need_new && bst_q[nb] == FREE) begin
      bst_d[nb] = FILLING;
      bch_d[nb] = chan_q;
      bcnt_d[nb] = CW'(1);
      bdrop_d[nb] = pend_q;
      pend_d = 1'b0;
      fill_act_d = 1'b1;
      fill_b_d = nb;
      we = 1'b1;
      wb = nb;
      waddr = '0;
    end else if (need_new) begin
      pend_d = 1'b1;
      drop_cnt_d = drop_cnt_q == 16'hFFFF ? drop_cnt_q : drop_cnt_q + 16'd1;
    end
    txs_d = txs_q;
    txb_d = txb_q;
    ptr_d = ptr_q;
    seq_d = seq_q;
    tv_d = tv_q;
    tl_d = tl_q;
    td_d = td_q;
    if (txs_q == IDLE && (bst_q[0] == READY || bst_q[1] == READY)) begin
      txb_d = pick;
      bst_d[pick] = SENDING;
      txs_d = HDR;
      tv_d = 1'b1;
      tl_d = 1'b0;
      td_d = HDR_MAGIC;
      ptr_d = BW'(1);
    end else if (txs_q != IDLE && tv_q && tx_ready && tl_q) begin
      tv_d = 1'b0;
      tl_d = 1'b0;
      txs_d = IDLE;
      bst_d[txb_q] = FREE;
      seq_d = seq_q + 16'd1;
    end else if (txs_q != IDLE && tv_q && tx_ready) begin
      // ptr_q names the byte being loaded next; payload bytes start at 8.
      td_d = ptr_q < BW'(8) ? hdr : p[0] ? word[7:0] : word[15:8];
      tl_d = ptr_q >= BW'(8) && p == BW'({bcnt_q[txb_q], 1'b0}) - BW'(1);
      txs_d = ptr_q < BW'(8) ? HDR : PAYLOAD;
      ptr_d = ptr_q + BW'(1);
    end
  end
  always_ff @(posedge clk)
    if (we) mem[wb][waddr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      chan_q <= '0;
      bst_q <= '{FREE, FREE};
      bch_q <= '{3'd0, 3'd0};
      bcnt_q <= '{CW'(0), CW'(0)};
      bdrop_q <= '{1'b0, 1'b0};
      fill_act_q <= 1'b0;
      fill_b_q <= 1'b0;
      older_q <= 1'b0;
      pend_q <= 1'b0;
      drop_cnt_q <= '0;
      seq_q <= '0;
      txs_q <= IDLE;
      txb_q <= 1'b0;
      ptr_q <= '0;
      td_q <= '0;
      tv_q <= 1'b0;
      tl_q <= 1'b0;
    end else begin
      v_q <= v_d;
      chan_q <= chan_d;
      bst_q <= bst_d;
      bch_q <= bch_d;
      bcnt_q <= bcnt_d;
      bdrop_q <= bdrop_d;
      fill_act_q <= fill_act_d;
      fill_b_q <= fill_b_d;
      older_q <= older_d;
      pend_q <= pend_d;
      drop_cnt_q <= drop_cnt_d;
      seq_q <= seq_d;
      txs_q <= txs_d;
      txb_q <= txb_d;
      ptr_q <= ptr_d;
      td_q <= td_d;
      tv_q <= tv_d;
      tl_q <= tl_d;
    end
  end
endmodule

// File: tb/tb_eth_frame_packer.sv
// tb_eth_frame_packer: directed self-checking bench for eth_frame_packer
module tb_eth_frame_packer;
  logic clk = 0, rst = 1, eth_en = 0, tx_ready = 1;
  logic [2:0] addr = 0;
  logic [15:0] din = 0;
  logic [7:0] tx_data;
  logic tx_valid, tx_last, busy;
  logic [15:0] drop_count;
  int n_tests = 0, n_fail = 0, stall_viol = 0;
  logic [8:0] q[$];
  logic [8:0] exp_q[$];
  bit prev_stall = 0;
  logic [7:0] pd;
  logic pl;
  logic [7:0] single_exp [16] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00,
                                  8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
  eth_frame_packer dut (
    .clk(clk), .rst(rst), .eth_en(eth_en), .addr(addr), .din(din),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall && (!tx_valid || tx_data !== pd || tx_last !== pl)) stall_viol++;
      if (tx_valid && tx_ready) q.push_back({tx_last, tx_data});
      prev_stall = tx_valid && !tx_ready;
      pd = tx_data;
      pl = tx_last;
    end
  end
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    eth_en = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    q.delete();
    exp_q.delete();
  endtask
  task automatic burst2(input int cha, input int na, input int chb, input int nb, input logic [15:0] base);
    int n = na + nb;
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      eth_en = i < n;
      addr = i < na ? 3'(cha) : 3'(chb);
      if (i > 0) din = base + 16'(i - 1);
    end
    @(posedge clk); #1;
    eth_en = 0;
  endtask
  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while (q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask
  task automatic mk_frame(input int ch, input int seq, input int cnt, input bit drop, input logic [15:0] base);
    logic [15:0] w;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'(ch)});
    exp_q.push_back({1'b0, 8'(seq >> 8)});
    exp_q.push_back({1'b0, 8'(seq)});
    exp_q.push_back({1'b0, 8'(cnt >> 8)});
    exp_q.push_back({1'b0, 8'(cnt)});
    exp_q.push_back({1'b0, 7'b0, drop});
    exp_q.push_back(9'h000);
    for (int i = 0; i < cnt; i++) begin
      w = base + 16'(i);
      exp_q.push_back({1'b0, w[15:8]});
      exp_q.push_back({i == cnt - 1, w[7:0]});
    end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (tx_valid !== 0 || tx_last !== 0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_tx valid=%b last=%b data=%h exp 0/0/00", tx_valid, tx_last, tx_data);
    end
    n_tests++;
    if (busy !== 0 || drop_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_status busy=%b drop=%h exp 0/0000", busy, drop_count);
    end
  endtask
  task automatic test_single();
    do_reset();
    tx_ready = 1;
    burst2(2, 4, 2, 0, 16'h0001);
    wait_bytes(16, 200);
    repeat (10) @(negedge clk);
    n_tests++;
    if (q.size() != 16) begin
      n_fail++;
      $display("FAIL single_len got %0d exp 16", q.size());
    end
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      n_tests++;
      if (q[i] !== {i == 15, single_exp[i]}) begin
        n_fail++;
        $display("FAIL single_byte[%0d] got %h exp %h", i, q[i], {i == 15, single_exp[i]});
      end
    end
    n_tests++;
    if (busy !== 0) begin
      n_fail++;
      $display("FAIL single_busy got %b exp 0", busy);
    end
    q.delete();
    burst2(2, 1, 2, 0, 16'h7777);
    mk_frame(2, 1, 1, 0, 16'h7777);
    wait_bytes(10, 200);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL seq1_byte[%0d] got %h exp %h", i, i < q.size() ? q[i] : 9'h1FF, exp_q[i]);
      end
    end
  endtask
  task automatic test_chan_switch();
    do_reset();
    tx_ready = 1;
    burst2(0, 3, 1, 2, 16'h0010);
    mk_frame(0, 0, 3, 0, 16'h0010);
    mk_frame(1, 1, 2, 0, 16'h0013);
    wait_bytes(26, 300);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL switch_byte[%0d] got %h exp %h", i, i < q.size() ? q[i] : 9'h1FF, exp_q[i]);
      end
    end
  endtask
  task automatic test_max();
    do_reset();
    tx_ready = 1;
    burst2(0, 1030, 0, 0, 16'h0000);
    mk_frame(0, 0, 1024, 0, 16'h0000);
    mk_frame(0, 1, 6, 0, 16'h0400);
    wait_bytes(2076, 6000);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL max_byte[%0d] got %h exp %h", i, i < q.size() ? q[i] : 9'h1FF, exp_q[i]);
      end
    end
    n_tests++;
    if (drop_count !== 16'h0) begin
      n_fail++;
      $display("FAIL max_drop got %h exp 0000", drop_count);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    tx_ready = 0;
    burst2(1, 2053, 1, 0, 16'h1000);
    repeat (5) @(negedge clk);
    n_tests++;
    if (drop_count !== 16'd5) begin
      n_fail++;
      $display("FAIL ovf_drop got %0d exp 5", drop_count);
    end
    @(posedge clk); #1;
    tx_ready = 1;
    wait_bytes(4112, 6000);
    n_tests++;
    if (q.size() != 4112) begin
      n_fail++;
      $display("FAIL ovf_len got %0d exp 4112", q.size());
    end
    n_tests++;
    if (q.size() > 2062 && (q[6] !== 9'h000 || q[2062] !== 9'h000)) begin
      n_fail++;
      $display("FAIL ovf_old_flags got %h/%h exp 000/000", q[6], q[2062]);
    end
    q.delete();
    burst2(4, 2, 4, 0, 16'hBEEF);
    mk_frame(4, 2, 2, 1, 16'hBEEF);
    wait_bytes(12, 300);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovf_byte[%0d] got %h exp %h", i, i < q.size() ? q[i] : 9'h1FF, exp_q[i]);
      end
    end
  endtask
  task automatic test_backpressure();
    logic [15:0] lfsr = 16'hACE1;
    int c = 0;
    do_reset();
    tx_ready = 0;
    burst2(3, 10, 3, 0, 16'h0A00);
    mk_frame(3, 0, 10, 0, 16'h0A00);
    repeat (4) @(posedge clk);
    while (q.size() < 28 && c < 600) begin
      @(posedge clk); #1;
      tx_ready = lfsr[0];
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      c++;
    end
    tx_ready = 1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_byte[%0d] got %h exp %h", i, i < q.size() ? q[i] : 9'h1FF, exp_q[i]);
      end
    end
    n_tests++;
    if (stall_viol != 0) begin
      n_fail++;
      $display("FAIL bp_stable got %0d unstable stalls exp 0", stall_viol);
    end
  endtask
  task automatic test_reset_mid();
    int lasts = 0;
    do_reset();
    tx_ready = 1;
    burst2(2, 10, 2, 0, 16'h0100);
    wait_bytes(13, 200);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (tx_valid !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL midrst_out valid=%b busy=%b exp 0/0", tx_valid, busy);
    end
    foreach (q[i]) if (q[i][8]) lasts++;
    n_tests++;
    if (q.size() < 13 || lasts != 0) begin
      n_fail++;
      $display("FAIL midrst_partial bytes=%0d lasts=%0d exp >=13/0", q.size(), lasts);
    end
    #1 rst = 0;
    q.delete();
    burst2(1, 3, 1, 0, 16'h0200);
    mk_frame(1, 0, 3, 0, 16'h0200);
    wait_bytes(14, 200);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_byte[%0d] got %h exp %h", i, i < q.size() ? q[i] : 9'h1FF, exp_q[i]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_chan_switch();
    test_max();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
